ilm_seq_ctrl: RTL

ILM_SEQ_CTRL -- requirements
Module: ilm_seq_ctrl

---
 rtl/ilm_pkg.sv | 29 ++
 rtl/ilm_seq_ctrl_nod.sv | 34 +++
 rtl/ilm_seq_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/ilm_pkg.sv
// Shared definitions for the iterative logarithmic multiplier sequencer:
// operand and product widths, FSM state encoding and the one-hot index helper.
package ilm_pkg;

  localparam int OPW = 8;
  localparam int PW  = 16;
  localparam int KW  = $clog2(OPW);
  localparam int QW  = OPW + 1;
  localparam int CW  = 18;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DET_A = 3'd1,
    DET_B = 3'd2,
    CALC  = 3'd3,
    DONE  = 3'd4
  } state_e;

  // OR-reduction of the bit positions; exact for a one-hot or all-zero input.
  function automatic logic [KW-1:0] onehot_to_idx(input logic [OPW-1:0] oh);
    logic [KW-1:0] idx;
    idx = '0;
    for (int i = 0; i < OPW; i++) begin
      if (oh[i]) idx = idx | KW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ilm_seq_ctrl_nod.sv
// 8-bit nearest-one detector: one-hot of the power of two closest to x_i,
// ties rounding up, saturating at the MSB; all-zero output for a zero input.
module ilm_nod
  import ilm_pkg::*;
(
  input  logic [OPW-1:0] x_i,
  output logic [OPW-1:0] oh_o
);

  logic [KW-1:0] lead;
  logic          found;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    lead  = '0;
    found = 1'b0;
    oh_o  = '0;
    for (int i = 0; i < OPW; i++) begin
      if (x_i[i]) begin
        lead  = KW'(i);
        found = 1'b1;
      end
    end
    // The bit below the leading one set means x >= 1.5 * 2^lead, so round up.
    if (found) begin
      if (lead != '0 && lead != KW'(OPW - 1) && x_i[lead - KW'(1)]) begin
        oh_o[lead + KW'(1)] = 1'b1;
      end else begin
        oh_o[lead] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ilm_seq_ctrl.sv
// Sequential approximate multiplier: one nearest-one detector is shared across
// operands A and B, then 2^(ka+kb) + qa*2^kb + qb*2^ka is formed and held.
module ilm_seq_ctrl
  import ilm_pkg::*;
#(
  parameter int OPW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [PW-1:0]  product,
  output logic           busy
);

  state_e state_q, state_d;

  logic [OPW-1:0]       a_q, b_q;
  logic [KW-1:0]        ka_q, kb_q;
  logic signed [QW-1:0] qa_q, qb_q;
  logic                 za_q, zb_q;
  logic [PW-1:0]        product_q;

  logic [OPW-1:0]       nod_in, nod_oh;
  logic [KW-1:0]        det_k;
  logic signed [QW-1:0] det_q;
  logic                 det_zero;

  logic [KW:0]          k_sum;
  logic signed [CW-1:0] t_pow, t_a, t_b, t_sum;
  logic [PW-1:0]        product_d;

  assign nod_in = (state_q == DET_B) ? b_q : a_q;

  ilm_nod u_nod (
    .x_i  (nod_in),
    .oh_o (nod_oh)
  );

  // The one-hot output is itself 2^k, so the residual needs no shifter.
  assign det_k    = onehot_to_idx(nod_oh);
  assign det_zero = (nod_oh == '0);
  assign det_q    = $signed({1'b0, nod_in}) - $signed({1'b0, nod_oh});

  always_comb begin
    k_sum     = {1'b0, ka_q} + {1'b0, kb_q};
    t_pow     = CW'(1) <<< k_sum;
    t_a       = CW'(qa_q) <<< kb_q;
    t_b       = CW'(qb_q) <<< ka_q;
    t_sum     = t_pow + t_a + t_b;
    product_d = (za_q || zb_q) ? '0 : t_sum[PW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = DET_A;
      DET_A:   state_d = DET_B;
      DET_B:   state_d = CALC;
      CALC:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      ka_q      <= '0;
      kb_q      <= '0;
      qa_q      <= '0;
      qb_q      <= '0;
      za_q      <= 1'b0;
      zb_q      <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
          end
        end
        DET_A: begin
          ka_q <= det_k;
          qa_q <= det_q;
          za_q <= det_zero;
        end
        DET_B: begin
          kb_q <= det_k;
          qb_q <= det_q;
          zb_q <= det_zero;
        end
        CALC:    product_q <= product_d;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = product_q;

endmodule
